// File: rtl/rv_shift_pipe.sv
// Pipelined shift/rotate unit for the integer execute stage.
// Ports: clk, rst_n (async low), flush; in_valid/in_ready with in_op,
//   in_word, in_a, in_amt; out_valid/out_ready with out_res.
//   in_op: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5-7 reserved (result 0).
//   in_word is ignored unless WORD_EN=1 and XLEN=64.
module rv_shift_pipe #(
    parameter int XLEN    = 32,
    parameter int STAGES  = 2,
    parameter int WORD_EN = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic                    in_word,
    input  logic [XLEN-1:0]         in_a,
    input  logic [$clog2(XLEN)-1:0] in_amt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_res
);

    localparam int AW  = $clog2(XLEN);
    localparam int PER = (AW + STAGES - 1) / STAGES;
    localparam bit WORD_OK = (WORD_EN != 0) && (XLEN == 64);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef struct packed {
        logic [XLEN-1:0] v;
        logic [AW-1:0]   amt;
        logic            fill;
        logic            rot;
        logic            rev;
        logic            word;
        logic            rsv;
    } stg_t;

    function automatic logic [XLEN-1:0] rev_x(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Right shift/rotate by the amount bits in [lo,hi) only.
    function automatic stg_t lvl_step(input stg_t s, input int lo,
                                      input int hi);
        stg_t r;
        int   sh;
        r = s;
        for (int k = 0; k < AW; k++) begin
            if (k >= lo && k < hi && s.amt[k]) begin
                sh = 1 << k;
                if (s.rot) begin
                    r.v = (r.v >> sh) | (r.v << (XLEN - sh));
                end else begin
                    r.v = (r.v >> sh)
                        | ({XLEN{s.fill}} & ~({XLEN{1'b1}} >> sh));
                end
            end
        end
        return r;
    endfunction

    // Undo the bit reversal of left ops and apply word sign extension.
    function automatic logic [XLEN-1:0] post_f(input stg_t s);
        logic [31:0]     r32;
        logic [63:0]     x64;
        logic [XLEN-1:0] r;
        r32 = s.rev ? rev32(s.v[31:0]) : s.v[31:0];
        x64 = {{32{r32[31]}}, r32};
        if (s.rsv) begin
            r = '0;
        end else if (s.word) begin
            r = x64[XLEN-1:0];
        end else begin
            r = s.rev ? rev_x(s.v) : s.v;
        end
        return r;
    endfunction

    logic              adv;
    logic              word_c;
    logic              is_left;
    logic              is_rot;
    logic              is_sra;
    logic              is_rsv;
    logic [31:0]       w32;
    logic [63:0]       wv64;
    stg_t              prep_c;
    stg_t              stg_d [STAGES];
    stg_t              stg_q [STAGES];
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vld_q;

    assign adv       = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign out_res   = post_f(stg_q[STAGES-1]);
    assign word_c    = WORD_OK && in_word;

    always_comb begin
        is_left = 1'b0;
        is_rot  = 1'b0;
        is_sra  = 1'b0;
        is_rsv  = 1'b0;
        unique case (in_op)
            OP_SLL:  is_left = 1'b1;
            OP_SRL:  is_left = 1'b0;
            OP_SRA:  is_sra  = 1'b1;
            OP_ROL: begin
                is_left = 1'b1;
                is_rot  = 1'b1;
            end
            OP_ROR:  is_rot  = 1'b1;
            default: is_rsv  = 1'b1;
        endcase
    end

    // Word rotates duplicate the 32-bit value so a full-width rotate
    // leaves the 32-bit rotation in the low half; word SRA pre-extends
    // the sign so the fill bit is bit 31.
    always_comb begin
        w32  = is_left ? rev32(in_a[31:0]) : in_a[31:0];
        wv64 = is_rot ? {w32, w32} : {{32{is_sra & w32[31]}}, w32};
        prep_c = '0;
        if (word_c) begin
            prep_c.v   = wv64[XLEN-1:0];
            prep_c.amt = AW'(in_amt[4:0]);
        end else begin
            prep_c.v   = is_left ? rev_x(in_a) : in_a;
            prep_c.amt = in_amt;
        end
        prep_c.fill = is_sra & prep_c.v[XLEN-1];
        prep_c.rot  = is_rot;
        prep_c.rev  = is_left;
        prep_c.word = word_c;
        prep_c.rsv  = is_rsv;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int LO = s * PER;
        localparam int HI = ((s + 1) * PER < AW) ? (s + 1) * PER : AW;
        stg_t src;
        if (s == 0) begin : g_first
            assign src = prep_c;
        end else begin : g_rest
            assign src = stg_q[s-1];
        end
        assign stg_d[s] = lvl_step(src, LO, HI);
    end

    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (adv) begin
            vld_d[0] = in_valid;
            for (int s = 1; s < STAGES; s++) vld_d[s] = vld_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) stg_q[s] <= '0;
        end else begin
            vld_q <= vld_d;
            if (adv) begin
                for (int s = 0; s < STAGES; s++) stg_q[s] <= stg_d[s];
            end
        end
    end

endmodule
